// File: rtl/pingpong_ram_buf.sv
// Two-bank ping-pong buffer: the writer fills one bank while the reader drains
// the other; banks change hands on wr_commit / rd_release.
module pingpong_ram_buf #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_commit,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic                  rd_release,
  output logic                  rd_avail,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic [1:0]            bank_full,
  output logic                  err_drop
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [2][DEPTH];
  logic              wr_sel;
  logic              rd_sel;
  logic [1:0]        bank_full_nxt;
  logic              wr_acc;
  logic              commit_acc;
  logic              rd_acc;
  logic              release_acc;
  logic              drop;

  // Handshake qualification: writer may only touch an empty bank, reader a full one
  assign wr_ready    = ~bank_full[wr_sel];
  assign rd_avail    = bank_full[rd_sel];
  assign wr_acc      = wr_en & wr_ready;
  assign commit_acc  = wr_commit & wr_ready;
  assign rd_acc      = rd_en & rd_avail;
  assign release_acc = rd_release & rd_avail;
  assign drop        = ((wr_en | wr_commit) & ~wr_ready) | ((rd_en | rd_release) & ~rd_avail);

  // Next full flags; commit and release always hit different banks
  always_comb begin
    bank_full_nxt = bank_full;
    if (commit_acc) begin
      bank_full_nxt[wr_sel] = 1'b1;
    end
    if (release_acc) begin
      bank_full_nxt[rd_sel] = 1'b0;
    end
  end

  // Ownership pointers, full flags and sticky drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      bank_full <= 2'b00;
      err_drop  <= 1'b0;
    end else begin
      bank_full <= bank_full_nxt;
      if (commit_acc) begin
        wr_sel <= ~wr_sel;
      end
      if (release_acc) begin
        rd_sel <= ~rd_sel;
      end
      if (drop) begin
        err_drop <= 1'b1;
      end
    end
  end

  // Byte-granular write into the writer-owned bank (storage is not reset)
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (wr_be[b]) begin
          mem[wr_sel][wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Registered read from the reader-owned bank, one-cycle valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem[rd_sel][rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_pingpong_ram_buf.sv
// Self-checking bench for pingpong_ram_buf: directed scenarios plus a random
// run, all checked against a commit/release-count model of bank ownership.
module tb_pingpong_ram_buf;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [BE_W-1:0]   wr_be;
  logic [DATA_W-1:0] wr_data;
  logic              wr_commit;
  logic              wr_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_release;
  logic              rd_avail;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [1:0]        bank_full;
  logic              err_drop;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: ownership follows from how many frames were committed/released
  logic [DATA_W-1:0] m_mem [2][DEPTH];
  bit                m_def [2][DEPTH];
  int                commits  = 0;
  int                releases = 0;
  logic [DATA_W-1:0] m_rd_data  = '0;
  bit                m_rd_known = 1'b1;
  bit                m_rd_valid = 1'b0;
  bit                m_err      = 1'b0;

  pingpong_ram_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_be      (wr_be),
    .wr_data    (wr_data),
    .wr_commit  (wr_commit),
    .wr_ready   (wr_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_release (rd_release),
    .rd_avail   (rd_avail),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .bank_full  (bank_full),
    .err_drop   (err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_wr_ready();
    return (commits - releases) < 2;
  endfunction

  function automatic bit m_rd_avail();
    return (commits - releases) > 0;
  endfunction

  function automatic logic [1:0] m_full();
    logic [1:0] f;
    int p;
    f = 2'b00;
    p = commits - releases;
    if (p == 2) f = 2'b11;
    else if (p == 1) f[releases % 2] = 1'b1;
    return f;
  endfunction

  task automatic model_reset();
    commits    = 0;
    releases   = 0;
    m_rd_data  = '0;
    m_rd_known = 1'b1;
    m_rd_valid = 1'b0;
    m_err      = 1'b0;
  endtask

  // One clock of stimulus; the model advances with the same inputs
  task automatic cyc(input logic we, input logic [ADDR_W-1:0] wa, input logic [BE_W-1:0] be,
                     input logic [DATA_W-1:0] wd, input logic wc, input logic re,
                     input logic [ADDR_W-1:0] ra, input logic rr);
    int  wb;
    int  rb;
    bit  wrdy;
    bit  ravl;
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; wr_commit = wc;
    rd_en = re; rd_addr = ra; rd_release = rr;
    wb   = commits % 2;
    rb   = releases % 2;
    wrdy = m_wr_ready();
    ravl = m_rd_avail();
    if (we && wrdy) begin
      for (int b = 0; b < int'(BE_W); b++)
        if (be[b]) m_mem[wb][wa][b*8 +: 8] = wd[b*8 +: 8];
      if (be == '1) m_def[wb][wa] = 1'b1;
    end
    m_rd_valid = re && ravl;
    if (m_rd_valid) begin
      m_rd_data  = m_mem[rb][ra];
      m_rd_known = m_def[rb][ra];
    end
    if (wc && wrdy) commits++;
    if (rr && ravl) releases++;
    if (((we || wc) && !wrdy) || ((re || rr) && !ravl)) m_err = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    wr_en = 0; wr_addr = '0; wr_be = '0; wr_data = '0; wr_commit = 0;
    rd_en = 0; rd_addr = '0; rd_release = 0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL reset_bank_full got %b exp 00", bank_full); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    n_checks++; if (err_drop !== 1'b0) begin n_fail++; $display("FAIL reset_err_drop got %b exp 0", err_drop); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    n_checks++; if (rd_avail !== 1'b0) begin n_fail++; $display("FAIL reset_rd_avail got %b exp 0", rd_avail); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pingpong();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, ADDR_W'(i), 8'hFF, 64'h1000 + 64'(i), 1'b0, 1'b0, '0, 1'b0);
      n_checks++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL pp_fill_full[%0d] got %b exp 00", i, bank_full); end
    end
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    n_checks++; if (bank_full !== 2'b01) begin n_fail++; $display("FAIL pp_commit_full got %b exp 01", bank_full); end
    n_checks++; if (rd_avail !== 1'b1) begin n_fail++; $display("FAIL pp_rd_avail got %b exp 1", rd_avail); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL pp_wr_ready got %b exp 1", wr_ready); end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, ADDR_W'(i), 1'b0);
      n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL pp_rd_valid[%0d] got %b exp 1", i, rd_valid); end
      n_checks++; if (rd_data !== 64'h1000 + 64'(i)) begin n_fail++; $display("FAIL pp_rd_data[%0d] got %h exp %h", i, rd_data, 64'h1000 + 64'(i)); end
    end
    idle();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL pp_valid_pulse got %b exp 0", rd_valid); end
    n_checks++; if (rd_data !== 64'h1007) begin n_fail++; $display("FAIL pp_rd_hold got %h exp 1007", rd_data); end
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL pp_release_full got %b exp 00", bank_full); end
  endtask

  task automatic test_byte_enable();
    cyc(1'b1, 3'd2, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 3'd2, 8'h0F, 64'h0, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    n_checks++; if (bank_full !== 2'b10) begin n_fail++; $display("FAIL be_full got %b exp 10", bank_full); end
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, 3'd2, 1'b0);
    n_checks++; if (rd_data !== 64'hFFFF_FFFF_0000_0000) begin n_fail++; $display("FAIL be_rd_data got %h exp ffffffff00000000", rd_data); end
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL be_release got %b exp 00", bank_full); end
  endtask

  task automatic test_underflow();
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, 3'd2, 1'b0);
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL uf_rd_valid got %b exp 0", rd_valid); end
    n_checks++; if (rd_data !== 64'hFFFF_FFFF_0000_0000) begin n_fail++; $display("FAIL uf_rd_data got %h exp ffffffff00000000", rd_data); end
    n_checks++; if (err_drop !== 1'b1) begin n_fail++; $display("FAIL uf_err_drop got %b exp 1", err_drop); end
    repeat (3) idle();
    n_checks++; if (err_drop !== 1'b1) begin n_fail++; $display("FAIL uf_err_sticky got %b exp 1", err_drop); end
  endtask

  task automatic test_overlap();
    for (int i = 0; i < 8; i++) cyc(1'b1, ADDR_W'(i), 8'hFF, 64'h2000 + 64'(i), 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    n_checks++; if (bank_full !== 2'b01) begin n_fail++; $display("FAIL ov_commit0 got %b exp 01", bank_full); end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, ADDR_W'(i), 8'hFF, 64'h3000 + 64'(i), 1'b0, 1'b1, ADDR_W'(i), 1'b0);
      n_checks++; if (rd_data !== 64'h2000 + 64'(i)) begin n_fail++; $display("FAIL ov_rd_data[%0d] got %h exp %h", i, rd_data, 64'h2000 + 64'(i)); end
    end
    n_checks++; if (err_drop !== 1'b0) begin n_fail++; $display("FAIL ov_no_err got %b exp 0", err_drop); end
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    n_checks++; if (bank_full !== 2'b11) begin n_fail++; $display("FAIL ov_both_full got %b exp 11", bank_full); end
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL ov_wr_ready got %b exp 0", wr_ready); end
    cyc(1'b1, 3'd0, 8'hFF, 64'hDEAD_BEEF, 1'b0, 1'b0, '0, 1'b0);
    n_checks++; if (err_drop !== 1'b1) begin n_fail++; $display("FAIL ov_err_drop got %b exp 1", err_drop); end
    n_checks++; if (bank_full !== 2'b11) begin n_fail++; $display("FAIL ov_full_kept got %b exp 11", bank_full); end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, ADDR_W'(i), 1'b0);
      n_checks++; if (rd_data !== 64'h2000 + 64'(i)) begin n_fail++; $display("FAIL ov_bank0_kept[%0d] got %h exp %h", i, rd_data, 64'h2000 + 64'(i)); end
    end
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (bank_full !== 2'b10) begin n_fail++; $display("FAIL ov_rel0 got %b exp 10", bank_full); end
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    n_checks++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL ov_rel1 got %b exp 00", bank_full); end
  endtask

  task automatic test_simultaneous();
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    n_checks++; if (bank_full !== 2'b01) begin n_fail++; $display("FAIL sim_pre got %b exp 01", bank_full); end
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
    n_checks++; if (bank_full !== 2'b10) begin n_fail++; $display("FAIL sim_full got %b exp 10", bank_full); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL sim_wr_ready got %b exp 1", wr_ready); end
    n_checks++; if (rd_avail !== 1'b1) begin n_fail++; $display("FAIL sim_rd_avail got %b exp 1", rd_avail); end
    // Write and commit together: the word must land in bank0
    cyc(1'b1, 3'd5, 8'hFF, 64'hABCD, 1'b1, 1'b0, '0, 1'b0);
    n_checks++; if (bank_full !== 2'b11) begin n_fail++; $display("FAIL sim_wr_commit got %b exp 11", bank_full); end
    // Read and release together: data comes from bank1 (the one released)
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, 3'd0, 1'b1);
    n_checks++; if (rd_data !== 64'h3000) begin n_fail++; $display("FAIL sim_rd_rel_data got %h exp 3000", rd_data); end
    n_checks++; if (bank_full !== 2'b01) begin n_fail++; $display("FAIL sim_rd_rel_full got %b exp 01", bank_full); end
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, 3'd5, 1'b0);
    n_checks++; if (rd_data !== 64'hABCD) begin n_fail++; $display("FAIL sim_bank0_data got %h exp abcd", rd_data); end
  endtask

  task automatic test_reset_mid();
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    n_checks++; if (bank_full !== 2'b11) begin n_fail++; $display("FAIL rm_pre got %b exp 11", bank_full); end
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, 3'd5, 1'b0);
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL rm_inflight got %b exp 1", rd_valid); end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL rm_full got %b exp 00", bank_full); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rm_rd_valid got %b exp 0", rd_valid); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rm_wr_ready got %b exp 1", wr_ready); end
    n_checks++; if (err_drop !== 1'b0) begin n_fail++; $display("FAIL rm_err_drop got %b exp 0", err_drop); end
    @(negedge clk);
    wr_en = 0; wr_commit = 0; rd_en = 0; rd_release = 0;
    rst_n = 1'b1;
    cyc(1'b1, 3'd1, 8'hFF, 64'h77, 1'b1, 1'b0, '0, 1'b0);
    n_checks++; if (bank_full !== 2'b01) begin n_fail++; $display("FAIL rm_first_frame got %b exp 01", bank_full); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 1)), ADDR_W'($urandom), BE_W'($urandom), {$urandom, $urandom},
          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), ADDR_W'($urandom),
          1'($urandom_range(0, 7) == 0));
      n_checks++; if (bank_full !== m_full()) begin n_fail++; $display("FAIL rnd_full[%0d] got %b exp %b", n, bank_full, m_full()); end
      n_checks++; if (wr_ready !== m_wr_ready()) begin n_fail++; $display("FAIL rnd_wr_ready[%0d] got %b exp %b", n, wr_ready, m_wr_ready()); end
      n_checks++; if (rd_avail !== m_rd_avail()) begin n_fail++; $display("FAIL rnd_rd_avail[%0d] got %b exp %b", n, rd_avail, m_rd_avail()); end
      n_checks++; if (rd_valid !== m_rd_valid) begin n_fail++; $display("FAIL rnd_rd_valid[%0d] got %b exp %b", n, rd_valid, m_rd_valid); end
      n_checks++; if (err_drop !== m_err) begin n_fail++; $display("FAIL rnd_err_drop[%0d] got %b exp %b", n, err_drop, m_err); end
      if (m_rd_known) begin
        n_checks++; if (rd_data !== m_rd_data) begin n_fail++; $display("FAIL rnd_rd_data[%0d] got %h exp %h", n, rd_data, m_rd_data); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_pingpong();
    test_byte_enable();
    test_underflow();
    test_reset();
    test_overlap();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pingpong_ram_buf.md
PINGPONG_RAM_BUF -- requirements
Module: pingpong_ram_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 64, data width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 3, word address width; each bank holds 2**ADDR_W words.
REQ-003 SHALL derive BE_W = DATA_W/8 internally as a localparam, not as a parameter.
REQ-004 SHALL have a single clock and asynchronous active-low reset, named clk and rst_n.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 wr_en  input  1  write strobe into the writer-owned bank.
REQ-008 wr_addr  input  ADDR_W  write word address.
REQ-009 wr_be  input  BE_W  byte enables; bit i covers data bits 8i+7..8i.
REQ-010 wr_data  input  DATA_W  write data.
REQ-011 wr_commit  input  1  writer done; hand the current bank to the reader.
REQ-012 wr_ready  output  1  writer-owned bank is empty and writable.
REQ-013 rd_en  input  1  read strobe from the reader-owned bank.
REQ-014 rd_addr  input  ADDR_W  read word address.
REQ-015 rd_release  input  1  reader done; return the current bank to the writer.
REQ-016 rd_avail  output  1  reader-owned bank holds committed data.
REQ-017 rd_data  output  DATA_W  registered read data.
REQ-018 rd_valid  output  1  rd_data updated this cycle.
REQ-019 bank_full  output  2  per-bank full flag; bit b is bank b.
REQ-020 err_drop  output  1  sticky flag: an access was dropped.

Function
REQ-021 SHALL contain two banks of 2**ADDR_W x DATA_W storage with byte-granular write.
REQ-022 SHALL hold wr_sel and rd_sel bank pointers, 1 bit each.
REQ-023 wr_ready SHALL equal ~bank_full[wr_sel], combinationally.
REQ-024 rd_avail SHALL equal bank_full[rd_sel], combinationally.
REQ-025 wr_en with wr_ready SHALL write bank wr_sel at wr_addr, updating only bytes whose wr_be bit is set.
REQ-026 wr_commit with wr_ready SHALL set bank_full[wr_sel] and toggle wr_sel at the same edge.
REQ-027 wr_en and wr_commit in the same cycle SHALL both take effect: the write lands in the bank being committed.
REQ-028 rd_en with rd_avail SHALL load rd_data from bank rd_sel at rd_addr and assert rd_valid on the next cycle (1-cycle latency).
REQ-029 rd_data SHALL hold its last value when no read is accepted; rd_valid SHALL be a single-cycle pulse per accepted read.
REQ-030 rd_release with rd_avail SHALL clear bank_full[rd_sel] and toggle rd_sel.
REQ-031 rd_en and rd_release in the same cycle SHALL both take effect: the read uses the bank being released and its data returns next cycle.
REQ-032 Commit and release in the same cycle SHALL both take effect; the two always target different banks.
REQ-033 Read and write in the same cycle SHALL never conflict, because they always target different banks.
REQ-034 wr_en or wr_commit while wr_ready=0 SHALL be ignored and SHALL set err_drop.
REQ-035 rd_en or rd_release while rd_avail=0 SHALL be ignored and SHALL set err_drop.
REQ-036 err_drop SHALL clear only on reset.
REQ-037 Ownership per bank, derived from the flags: EMPTY, then COMMITTED (on commit), then EMPTY (on release).
REQ-038 Ownership SHALL cycle strictly in order bank0, bank1, bank0, ... for both writer and reader.

Reset
REQ-039 While rst_n=0, the block SHALL hold wr_sel=0, rd_sel=0, bank_full=00, rd_valid=0, rd_data=0 and err_drop=0.
REQ-040 After reset: wr_ready=1 and rd_avail=0.
REQ-041 Bank storage SHALL NOT be reset.
REQ-042 Reset mid-frame SHALL discard all committed and partial data logically; the first post-reset frame goes to bank0.

Verification (DATA_W=64, ADDR_W=3)
REQ-043 Ping-pong: write 8 words 0x1000+i into bank0 with be=FF, then commit; bank_full=01 and rd_avail=1. Read addr 0..7: each rd_data=0x1000+i one cycle after rd_en. Release: bank_full=00.
REQ-044 Byte enables: write 0xFFFF_FFFF_FFFF_FFFF to addr 2 with be=FF, then 0 with be=0F; commit and read addr 2 -> 0xFFFF_FFFF_0000_0000.
REQ-045 Overlap: commit bank0, then fill and commit bank1 while reading bank0. Both full gives wr_ready=0. A further wr_en is dropped, err_drop=1, and bank0 contents are unchanged.
REQ-046 Simultaneous: with bank_full=01, assert wr_commit (bank1) and rd_release (bank0) in one cycle -> bank_full=10, wr_sel=0, rd_sel=1.
REQ-047 Underflow: rd_en with rd_avail=0 -> rd_valid stays 0, rd_data unchanged, err_drop=1.
REQ-048 Reset mid-operation: with bank_full=11 and a read in flight, pulse rst_n low -> bank_full=00, rd_valid=0, wr_ready=1, err_drop=0.
